beam_sweep_generator: RTL and testbench

//  Raster timing source for the 1024x768@60 display path. Sweeps the beam over
//  the full H/V frame, including blanking. Drives beam_x/beam_y/draw into the

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/sweep_axis_counter.sv | 35 +++
 rtl/beam_sweep_generator.sv | 136 +++++++++++++
 tb/tb_beam_sweep_generator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing types and defaults for the beam sweep generator.
// Contents:
//   beam_x_t / beam_y_t  column and row coordinate types
//   *_DEF constants       1024x768@60 timing (H_TOTAL 1344, V_TOTAL 806)
//   in_window()           true when lo <= val < lo + len
package vga_timing_pkg;

  typedef logic [10:0] beam_x_t;
  typedef logic [9:0]  beam_y_t;

  localparam int H_ACTIVE_DEF   = 1024;
  localparam int H_FRONT_DEF    = 24;
  localparam int H_SYNC_DEF     = 136;
  localparam int H_BACK_DEF     = 160;
  localparam int V_ACTIVE_DEF   = 768;
  localparam int V_FRONT_DEF    = 3;
  localparam int V_SYNC_DEF     = 6;
  localparam int V_BACK_DEF     = 29;
  localparam int SYNC_DELAY_DEF = 1;

  function automatic logic in_window(input int val, input int lo, input int len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/sweep_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 while en is high and wraps to 0.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset; loads TOTAL-1 so the first enabled
//          step lands on 0
//   en     advance enable
//   count  current position (register)
//   wrap   high while count sits on its terminal value TOTAL-1
module sweep_axis_counter #(
  parameter int TOTAL = 1344,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

  logic [WIDTH-1:0] r_count;

  assign wrap  = (r_count == LAST);
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= LAST;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/beam_sweep_generator.sv
// Raster timing source: sweeps the beam over the full H/V frame including
// blanking, producing coordinates, draw enable, delayed syncs and strobes.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   pix_en           pixel advance enable
//   beam_x, beam_y   current pixel coordinates
//   draw             pixel is inside the visible area
//   hsync, vsync     sync levels, SYNC_DELAY enabled pixels behind the beam
//   line_start       one-clk pulse when outputs show x == 0
//   frame_start      one-clk pulse when outputs show (0,0)
//   vblank_start     one-clk pulse when outputs show (0,V_ACTIVE)
//   frame_count      frame counter, increments on every wrap to (0,0)
module beam_sweep_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] beam_x,
  output logic [9:0]  beam_y,
  output logic        draw,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2048) begin : g_h_range
    $error("H_TOTAL does not fit beam_x");
  end
  if (V_TOTAL > 1024) begin : g_v_range
    $error("V_TOTAL does not fit beam_y");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_dly_range
    $error("SYNC_DELAY must be 0..4");
  end

  localparam beam_x_t H_ACT_X  = beam_x_t'(H_ACTIVE);
  localparam beam_y_t V_ACT_Y  = beam_y_t'(V_ACTIVE);

  beam_x_t w_x, w_x_nxt;
  beam_y_t w_y, w_y_nxt;
  logic    w_h_wrap, w_v_wrap, w_v_en;
  logic    w_hs_act, w_vs_act;

  logic        r_draw, r_line, r_frame, r_vblank;
  logic [15:0] r_frame_cnt;
  // index 0 tracks the beam; index SYNC_DELAY is what leaves the block
  logic        r_hs_pipe [0:SYNC_DELAY];
  logic        r_vs_pipe [0:SYNC_DELAY];

  assign w_v_en = pix_en & w_h_wrap;

  sweep_axis_counter #(.TOTAL(H_TOTAL), .WIDTH(11)) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .count (w_x),
    .wrap  (w_h_wrap)
  );

  sweep_axis_counter #(.TOTAL(V_TOTAL), .WIDTH(10)) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .en    (w_v_en),
    .count (w_y),
    .wrap  (w_v_wrap)
  );

  // Registered outputs are computed from the coordinates the counters are
  // about to take, so draw/strobes land in the same clk as beam_x/beam_y.
  assign w_x_nxt  = w_h_wrap ? '0 : w_x + beam_x_t'(1);
  assign w_y_nxt  = !w_h_wrap ? w_y : (w_v_wrap ? '0 : w_y + beam_y_t'(1));
  assign w_hs_act = in_window(int'(w_x_nxt), H_ACTIVE + H_FRONT, H_SYNC);
  assign w_vs_act = in_window(int'(w_y_nxt), V_ACTIVE + V_FRONT, V_SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_draw      <= 1'b0;
      r_line      <= 1'b0;
      r_frame     <= 1'b0;
      r_vblank    <= 1'b0;
      r_frame_cnt <= '0;
      for (int i = 0; i <= SYNC_DELAY; i++) begin
        r_hs_pipe[i] <= ~HSYNC_POL;
        r_vs_pipe[i] <= ~VSYNC_POL;
      end
    end else if (pix_en) begin
      r_draw   <= (w_x_nxt < H_ACT_X) && (w_y_nxt < V_ACT_Y);
      r_line   <= (w_x_nxt == '0);
      r_frame  <= (w_x_nxt == '0) && (w_y_nxt == '0);
      r_vblank <= (w_x_nxt == '0) && (w_y_nxt == V_ACT_Y);
      if (w_h_wrap && w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      r_hs_pipe[0] <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vs_pipe[0] <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
    end else begin
      r_line   <= 1'b0;
      r_frame  <= 1'b0;
      r_vblank <= 1'b0;
    end
  end

  assign beam_x       = w_x;
  assign beam_y       = w_y;
  assign draw         = r_draw;
  assign hsync        = r_hs_pipe[SYNC_DELAY];
  assign vsync        = r_vs_pipe[SYNC_DELAY];
  assign line_start   = r_line;
  assign frame_start  = r_frame;
  assign vblank_start = r_vblank;
  assign frame_count  = r_frame_cnt;

endmodule

// File: tb/tb_beam_sweep_generator.sv
module tb_beam_sweep_generator;

  // Reduced raster so several frames fit in a short run.
  localparam int HA = 16, HF = 2, HS = 3, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] bx0, bx1;
  logic [9:0]  by0, by1;
  logic        dr0, dr1, hs0, hs1, vs0, vs1, ls0, ls1, fs0, fs1, vb0, vb1;
  logic [15:0] fc0, fc1;

  // dut0: delayed, active-low syncs. dut1: undelayed, active-high syncs.
  beam_sweep_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SYNC_DELAY(2)
  ) dut0 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .beam_x(bx0), .beam_y(by0), .draw(dr0), .hsync(hs0), .vsync(vs0),
    .line_start(ls0), .frame_start(fs0), .vblank_start(vb0), .frame_count(fc0)
  );

  beam_sweep_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SYNC_DELAY(0)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .beam_x(bx1), .beam_y(by1), .draw(dr1), .hsync(hs1), .vsync(vs1),
    .line_start(ls1), .frame_start(fs1), .vblank_start(vb1), .frame_count(fc1)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        draw, hs, vs, ls, fs, vbs;
    logic [15:0] fc;
  } outs_t;

  outs_t q0[$], q1[$];
  int n_checks = 0;
  int n_pass = 0;

  // Reference model: linear pixel index within the frame plus history of
  // sync-window membership for each enabled pixel.
  int p;
  int fc;
  bit hw[$], vw[$];
  bit m_ls, m_fs, m_vbs;

  task automatic model_step(input bit r, input bit e);
    int x, y;
    if (r) begin
      p = FT - 1;
      fc = 0;
      hw.delete();
      vw.delete();
      m_ls = 0; m_fs = 0; m_vbs = 0;
    end else if (e) begin
      p = (p + 1) % FT;
      if (p == 0) fc = (fc + 1) % 65536;
      x = p % HT;
      y = p / HT;
      hw.push_back((x >= HA + HF) && (x < HA + HF + HS));
      vw.push_back((y >= VA + VF) && (y < VA + VF + VS));
      while (hw.size() > 8) void'(hw.pop_front());
      while (vw.size() > 8) void'(vw.pop_front());
      m_ls  = (x == 0);
      m_fs  = (p == 0);
      m_vbs = (x == 0) && (y == VA);
    end else begin
      m_ls = 0; m_fs = 0; m_vbs = 0;
    end
  endtask

  function automatic outs_t exp_out(input int d, input bit hp, input bit vp);
    outs_t o;
    int x, y;
    bit ha, va;
    x = p % HT;
    y = p / HT;
    ha = (hw.size() > d) ? hw[hw.size() - 1 - d] : 1'b0;
    va = (vw.size() > d) ? vw[vw.size() - 1 - d] : 1'b0;
    o.x    = 11'(x);
    o.y    = 10'(y);
    o.draw = (x < HA) && (y < VA);
    o.hs   = ha ? hp : !hp;
    o.vs   = va ? vp : !vp;
    o.ls   = m_ls;
    o.fs   = m_fs;
    o.vbs  = m_vbs;
    o.fc   = 16'(fc);
    return o;
  endfunction

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, id, act, exp, $time);
  endtask

  task automatic compare(input int id, input outs_t a, input outs_t e);
    chk("beam_x", id, int'(a.x), int'(e.x));
    chk("beam_y", id, int'(a.y), int'(e.y));
    chk("draw", id, int'(a.draw), int'(e.draw));
    chk("hsync", id, int'(a.hs), int'(e.hs));
    chk("vsync", id, int'(a.vs), int'(e.vs));
    chk("line_start", id, int'(a.ls), int'(e.ls));
    chk("frame_start", id, int'(a.fs), int'(e.fs));
    chk("vblank_start", id, int'(a.vbs), int'(e.vbs));
    chk("frame_count", id, int'(a.fc), int'(e.fc));
  endtask

  task automatic step(input bit r, input bit e);
    reset  = r;
    pix_en = e;
    model_step(r, e);
    q0.push_back(exp_out(2, 1'b0, 1'b0));
    q1.push_back(exp_out(0, 1'b1, 1'b1));
    @(posedge clk);
    #1;
  endtask

  // Monitor: the outputs of every clk are compared against the oldest
  // pending expectation.
  initial begin
    outs_t a0, a1;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        a0 = '{x: bx0, y: by0, draw: dr0, hs: hs0, vs: vs0, ls: ls0, fs: fs0, vbs: vb0, fc: fc0};
        compare(0, a0, q0.pop_front());
      end
      if (q1.size() > 0) begin
        a1 = '{x: bx1, y: by1, draw: dr1, hs: hs1, vs: vs1, ls: ls1, fs: fs1, vbs: vb1, fc: fc1};
        compare(1, a1, q1.pop_front());
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (2 * FT + 10) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (400) step(1'b0, $urandom_range(0, 3) != 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (FT + 5) step(1'b0, 1'b1);
    repeat (900) step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
    step(1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("drain_q0", 0, q0.size(), 0);
    chk("drain_q1", 1, q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
